// File: rtl/pix_skid_buf.sv
// Two-entry valid/ready buffer: one output register backed by one skid register.
// Ready is registered and is the inverse of skid occupancy.
module pix_skid_buf #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  s_ready_q,   s_ready_d;
    logic                  s_fire;
    logic                  out_free;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        s_fire       = s_valid && s_ready_q;
        out_free     = !out_valid_q || m_ready;

        if (out_free) begin
            // A parked skid entry always goes out before any new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (s_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = s_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (s_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_data;
        end

        s_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = out_valid_q;
    assign m_data  = out_data_q;

endmodule

// File: rtl/pix_border_overlay.sv
// Paints a BORDER_PX-wide frame of BORDER_RGB over a raster pixel stream.
// Define PIX_BORDER_OVERLAY_CROSSHAIR_EN to also paint a one-pixel centre crosshair.
module pix_border_overlay #(
    parameter int                         COLOR_WIDTH = 4,
    parameter int                         H_WIDTH     = 12,
    parameter int                         V_WIDTH     = 12,
    parameter int                         BORDER_PX   = 1,
    parameter logic [3*COLOR_WIDTH-1:0]   BORDER_RGB  = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   overlay_en,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [V_WIDTH-1:0]     v_visible,
    input  logic                   s_pix_valid,
    input  logic [COLOR_WIDTH-1:0] s_pix_red,
    input  logic [COLOR_WIDTH-1:0] s_pix_grn,
    input  logic [COLOR_WIDTH-1:0] s_pix_blu,
    output logic                   s_pix_ready,
    output logic                   m_pix_valid,
    output logic [COLOR_WIDTH-1:0] m_pix_red,
    output logic [COLOR_WIDTH-1:0] m_pix_grn,
    output logic [COLOR_WIDTH-1:0] m_pix_blu,
    input  logic                   m_pix_ready
);

    localparam int                 PIX_W    = 3 * COLOR_WIDTH;
    localparam logic [H_WIDTH-1:0] BORDER_H = H_WIDTH'(BORDER_PX);
    localparam logic [V_WIDTH-1:0] BORDER_V = V_WIDTH'(BORDER_PX);

    logic [H_WIDTH-1:0] x_q, x_d;
    logic [V_WIDTH-1:0] y_q, y_d;
    logic               s_fire;
    logic               border_hit;
    logic               overlay_hit;
    logic [PIX_W-1:0]   ovl_pix;
    logic [PIX_W-1:0]   m_pix;

    always_comb begin
        s_fire     = s_pix_valid && s_pix_ready;
        border_hit = (x_q < BORDER_H) || (x_q >= h_visible - BORDER_H) ||
                     (y_q < BORDER_V) || (y_q >= v_visible - BORDER_V);
`ifdef PIX_BORDER_OVERLAY_CROSSHAIR_EN
        overlay_hit = border_hit || (x_q == (h_visible >> 1)) || (y_q == (v_visible >> 1));
`else
        overlay_hit = border_hit;
`endif
        ovl_pix = (overlay_en && overlay_hit) ? BORDER_RGB : {s_pix_red, s_pix_grn, s_pix_blu};
    end

    // The counters tag the pixel being accepted, so they only move on an input transfer.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (s_fire) begin
            if (x_q == h_visible - H_WIDTH'(1)) begin
                x_d = '0;
                y_d = (y_q == v_visible - V_WIDTH'(1)) ? '0 : y_q + V_WIDTH'(1);
            end else begin
                x_d = x_q + H_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    pix_skid_buf #(
        .DATA_WIDTH(PIX_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_pix_valid),
        .s_data  (ovl_pix),
        .s_ready (s_pix_ready),
        .m_valid (m_pix_valid),
        .m_data  (m_pix),
        .m_ready (m_pix_ready)
    );

    assign m_pix_red = m_pix[PIX_W-1 -: COLOR_WIDTH];
    assign m_pix_grn = m_pix[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
    assign m_pix_blu = m_pix[COLOR_WIDTH-1:0];

endmodule

// File: tb/tb_pix_border_overlay.sv
// Randomized bench for pix_border_overlay against a queue-based frame-position reference model.
// Honours PIX_BORDER_OVERLAY_CROSSHAIR_EN when the design is built with it.
module tb_pix_border_overlay;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        overlay_en = 1'b0;
    logic [11:0] h_visible = 12'(H);
    logic [11:0] v_visible = 12'(V);
    logic        s_pix_valid = 1'b0;
    logic [3:0]  s_pix_red = '0, s_pix_grn = '0, s_pix_blu = '0;
    logic        s_pix_ready;
    logic        m_pix_valid;
    logic [3:0]  m_pix_red, m_pix_grn, m_pix_blu;
    logic        m_pix_ready = 1'b1;

    always #5 clk = ~clk;

    pix_border_overlay dut (
        .clk         (clk),
        .rst         (rst),
        .overlay_en  (overlay_en),
        .h_visible   (h_visible),
        .v_visible   (v_visible),
        .s_pix_valid (s_pix_valid),
        .s_pix_red   (s_pix_red),
        .s_pix_grn   (s_pix_grn),
        .s_pix_blu   (s_pix_blu),
        .s_pix_ready (s_pix_ready),
        .m_pix_valid (m_pix_valid),
        .m_pix_red   (m_pix_red),
        .m_pix_grn   (m_pix_grn),
        .m_pix_blu   (m_pix_blu),
        .m_pix_ready (m_pix_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the colour a pixel at frame index pos must leave the block with.
    function automatic logic [11:0] exp_pix(input int pos, input bit en, input logic [11:0] d);
        int  x, y;
        bit  hit;
        x   = pos % H;
        y   = pos / H;
        hit = (x < 1) || (x >= H - 1) || (y < 1) || (y >= V - 1);
`ifdef PIX_BORDER_OVERLAY_CROSSHAIR_EN
        hit = hit || (x == H / 2) || (y == V / 2);
`endif
        return (en && hit) ? 12'hFFF : d;
    endfunction

    logic [11:0] exp_q[$];
    int          pos       = 0;
    bit          rst_prev  = 1'b1;
    bit          last_acc  = 1'b0;
    int          acc_cnt   = 0;
    int          fire_cnt  = 0;
    int          ff_cnt    = 0;
    int          cyc       = 0;
    logic [11:0] last_out  = '0;
    logic [11:0] m_data;

    assign m_data = {m_pix_red, m_pix_grn, m_pix_blu};

    // Check outputs half a cycle after the edge, then advance the model for the coming edge.
    always @(negedge clk) begin
        cyc++;
        check("m_valid", 32'(m_pix_valid), 32'(exp_q.size() > 0));
        if (m_pix_valid && exp_q.size() > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
        check("s_ready", 32'(s_pix_ready), 32'(!rst_prev && exp_q.size() < 2));
        if (rst_prev) check("rst_rgb", 32'(m_data), 32'h0);

        last_acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            pos = 0;
        end else begin
            if (m_pix_valid && m_pix_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                fire_cnt++;
                if (m_data == 12'hFFF) ff_cnt++;
                last_out = m_data;
            end
            if (s_pix_valid && s_pix_ready) begin
                exp_q.push_back(exp_pix(pos, overlay_en, {s_pix_red, s_pix_grn, s_pix_blu}));
                pos = (pos + 1) % (H * V);
                acc_cnt++;
                last_acc = 1'b1;
            end
        end
        rst_prev = rst;
    end

    bit rand_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_pix_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pix(input logic [11:0] d, input bit en);
        int n;
        s_pix_valid = 1'b1;
        {s_pix_red, s_pix_grn, s_pix_blu} = d;
        overlay_en = en;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 200);
        if (n >= 200) check("send_timeout", 32'd0, 32'd1);
        s_pix_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_rdy    = 1'b0;
        m_pix_ready = 1'b1;
        s_pix_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    int          f0, a0, c0;
    logic [11:0] d;
    int          ff_exp;

    initial begin
`ifdef PIX_BORDER_OVERLAY_CROSSHAIR_EN
        ff_exp = 27;
`else
        ff_exp = 20;
`endif
        // Reset state: checked continuously by the monitor while rst is high.
        do_reset();

        // Full frame of 0x555 with overlay on, back-to-back at one pixel per cycle.
        f0 = fire_cnt; ff_cnt = 0; c0 = cyc;
        for (int i = 0; i < H * V; i++) send_pix(12'h555, 1'b1);
        check("frame_cycles", 32'(cyc - c0), 32'(H * V));
        drain();
        check("frame_outputs", 32'(fire_cnt - f0), 32'(H * V));
        check("border_count", 32'(ff_cnt), 32'(ff_exp));

        // Same frame with overlay off passes through untouched.
        f0 = fire_cnt; ff_cnt = 0;
        for (int i = 0; i < H * V; i++) send_pix(12'h555, 1'b0);
        drain();
        check("bypass_outputs", 32'(fire_cnt - f0), 32'(H * V));
        check("bypass_border", 32'(ff_cnt), 32'd0);

        // Three frames of counter data with random backpressure, gaps and overlay toggles.
        f0 = fire_cnt;
        rand_rdy = 1'b1;
        for (int i = 0; i < 3 * H * V; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send_pix(12'(i), 1'($urandom_range(0, 3) != 0));
        end
        drain();
        check("random_outputs", 32'(fire_cnt - f0), 32'(3 * H * V));

        // Stall with continuous valid: exactly two accepted, then both drain back to back.
        m_pix_ready = 1'b0;
        a0 = acc_cnt;
        d = 12'h321;
        s_pix_valid = 1'b1;
        {s_pix_red, s_pix_grn, s_pix_blu} = d;
        overlay_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) begin
                d = d + 12'h1;
                {s_pix_red, s_pix_grn, s_pix_blu} = d;
            end
        end
        check("stall_accepts", 32'(acc_cnt - a0), 32'd2);
        s_pix_valid = 1'b0;
        m_pix_ready = 1'b1;
        f0 = fire_cnt;
        tick();
        tick();
        check("stall_release", 32'(fire_cnt - f0), 32'd2);
        drain();

        // Mid-frame reset after pixel (3,1) with a pixel still buffered.
        do_reset();
        for (int i = 0; i < 11; i++) send_pix(12'h555, 1'b1);
        m_pix_ready = 1'b0;
        send_pix(12'h555, 1'b1);
        check("pre_rst_pos", 32'(pos), 32'(1 * H + 3 + 1));
        do_reset();
        m_pix_ready = 1'b1;
        f0 = fire_cnt;
        send_pix(12'h555, 1'b1);
        drain();
        check("post_rst_count", 32'(fire_cnt - f0), 32'd1);
        check("post_rst_border", 32'(last_out), 32'hFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pix_border_overlay.md
PIX_BORDER_OVERLAY -- requirements
Module: pix_border_overlay

Interface
REQ-001 Parameter COLOR_WIDTH, default 4, bits per colour channel.
REQ-002 Parameter H_WIDTH, default 12, width of horizontal counter and h_visible.
REQ-003 Parameter V_WIDTH, default 12, width of vertical counter and v_visible.
REQ-004 Parameter BORDER_PX, default 1, border thickness in pixels; legal range 1..h_visible/2.
REQ-005 Parameter BORDER_RGB, default all-ones (3*COLOR_WIDTH bits), overlay colour as {red, grn, blu}.
REQ-006 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 Port rst  input  1  reset; synchronous and active-high.
REQ-008 Port overlay_en  input  1  overlay enabled when high; data passes unmodified when low.
REQ-009 Port h_visible  input  H_WIDTH  visible pixels per line; static while out of reset.
REQ-010 Port v_visible  input  V_WIDTH  visible lines per frame; static while out of reset.
REQ-011 Port s_pix_valid/s_pix_red/s_pix_grn/s_pix_blu  input  1/CW/CW/CW  upstream pixel stream, raster order.
REQ-012 Port s_pix_ready  output  1  upstream backpressure.
REQ-013 Port m_pix_valid/m_pix_red/m_pix_grn/m_pix_blu  output  1/CW/CW/CW  downstream pixel stream, suitable for svc_pix_vga s_pix_* ports.
REQ-014 Port m_pix_ready  input  1  downstream backpressure.

Function
REQ-015 Transfer occurs on a side only when valid and ready are both high in the same cycle; data is held stable while valid is high and ready is low.
REQ-016 Block SHALL sustain one pixel per cycle when m_pix_ready is continuously high; latency from s_ transfer to m_pix_valid is exactly 1 cycle.
REQ-017 Datapath: one output register plus one skid register; s_pix_ready is registered and equals NOT skid_valid.
REQ-018 Skid: when output register is full and m_pix_ready is low, an accepted input goes to skid; skid drains to output on the next m_ transfer before new input is accepted.
REQ-019 Position counters x (H_WIDTH) and y (V_WIDTH) advance only on s_ transfer; they tag the pixel being accepted.
REQ-020 Wrap: x == h_visible-1 -> x=0 and y increments; at x == h_visible-1 and y == v_visible-1 both reset to 0.
REQ-021 Border hit when x < BORDER_PX, or x >= h_visible-BORDER_PX, or y < BORDER_PX, or y >= v_visible-BORDER_PX; comparisons unsigned at counter width.
REQ-022 When overlay_en and border hit, the stored pixel is BORDER_RGB; otherwise the input pixel unchanged.
REQ-023 overlay_en is sampled on the accepting cycle; a change mid-frame affects only subsequently accepted pixels.
REQ-024 Simultaneous m_ transfer and s_ transfer with the skid empty: the output register reloads in the same cycle with no bubble.

Reset
REQ-025 While rst is high: m_pix_valid=0, skid empty, s_pix_ready=0, x=0, y=0; colour outputs are 0.
REQ-026 s_pix_ready rises in the first cycle after rst deasserts.
REQ-027 Reset mid-frame discards buffered pixels; the next accepted pixel is treated as (0,0).

Configuration
REQ-028 Macro PIX_BORDER_OVERLAY_CROSSHAIR_EN, when defined, also makes x == h_visible>>1 or y == v_visible>>1 an overlay hit (one-pixel centre crosshair) gated by overlay_en.
REQ-029 Without PIX_BORDER_OVERLAY_CROSSHAIR_EN, only REQ-021 hits apply and no crosshair comparators are built.

Structure
REQ-030 No new package; colour constants stay with svc_rgb macros; BORDER_RGB is a module parameter.
REQ-031 Skid/output buffering is a sub-module pix_skid_buf (parameter DATA_WIDTH); counter and overlay logic stay in the top.

Verification
REQ-032 h_visible=8, v_visible=4, BORDER_PX=1, overlay_en=1, input all 0x5 colours, m_pix_ready=1 -> 32 outputs; rows 0 and 3 and columns 0 and 7 equal 0xF, rest 0x5; one per cycle after 1-cycle latency.
REQ-033 Same config, overlay_en=0 -> 32 outputs identical to input.
REQ-034 Input pixel counter value, m_pix_ready toggled pseudo-randomly over 3 frames -> output sequence equals input sequence with border substitution, no loss or duplication, data stable while stalled.
REQ-035 m_pix_ready held low for 5 cycles with s_pix_valid=1 -> exactly 2 pixels accepted, s_pix_ready=0 from the following cycle; release -> both emitted in order on consecutive cycles.
REQ-036 rst pulsed after pixel (3,1) -> m_pix_valid=0 during rst, next accepted pixel treated as (0,0) and overlaid as border.
REQ-037 With PIX_BORDER_OVERLAY_CROSSHAIR_EN, h_visible=8, v_visible=4 -> column 4 and row 2 also 0xF.
